biquad_sequencer: RTL and testbench
===================================

Name: biquad_sequencer

Overview:
Time-multiplexed controller that runs NUM_STAGES cascaded direct-form-I biquad stages (lowpass/highpass/EQ sections of the channel strip) on one shared multiply-accumulate unit.
- Accepts one audio sample per handshake and sequences the 5 taps of every stage.
- Owns per-stage history and a double-buffered coefficient bank, written over a config port and swapped only between samples.
- Sits between the sample-rate input stage and the output DAC path.

Parameters:
NUM_STAGES, 2, number of cascaded biquad stages
DATA_W, 16, sample width, signed Q1.15
COEF_W, 16, coefficient width, signed Q2.14
COEF_FRAC, 14, coefficient fractional bits
ACC_W, 40, accumulator width, signed

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_sample  in  DATA_W  input sample
in_valid  in  1  input sample present
in_ready  out  1  high only in IDLE
out_sample  out  DATA_W  filtered sample, registered
out_valid  out  1  one-cycle pulse, out_sample valid
cfg_we  in  1  shadow coefficient write strobe
cfg_addr  in  $clog2(5*NUM_STAGES)  stage*5+tap
cfg_data  in  COEF_W  coefficient value
cfg_commit  in  1  request shadow-to-active swap
commit_pending  out  1  swap requested, not yet applied
overrun  out  1  sticky, sample offered while busy
clip  out  1  valid with out_valid; any stage saturated this sample

Behaviour:
- Reset (async): state IDLE; in_ready=1; out_sample=0; out_valid=0; overrun=0; clip=0; commit_pending=0; all history=0.
  - Active and shadow banks reset to passthrough: b0=16384 (1.0); b1, b2, na1, na2 = 0.
  - Reset mid-sample aborts the sample with no output.
- Stage equation: y = b0*x + b1*x1 + b2*x2 + na1*y1 + na2*y2.
  - na1 and na2 are stored pre-negated (-a1, -a2), so every tap adds.
- Tap order: 0 b0·x, 1 b1·x1, 2 b2·x2, 3 na1·y1, 4 na2·y2.
- FSM states: IDLE, MAC, WB, DONE.
  - IDLE, edge with in_valid: latch x; stage=0; tap=0; acc=2^(COEF_FRAC-1) for round-half-up; go to MAC.
  - MAC, each edge: acc += sign-extended DATA_W×COEF_W product; tap++. At tap 4, go to WB.
  - WB: r = acc >>> COEF_FRAC (arithmetic shift), saturated to [-32768, 32767]. A saturation sets the internal clip flag.
    - Stage history update: x2<=x1, x1<=stage input, y2<=y1, y1<=r.
    - r becomes the next stage's input.
    - If not the last stage: stage++, tap=0, reset acc to the rounding constant, go to MAC.
    - If the last stage: out_sample<=r, go to DONE.
  - DONE: out_valid=1 and clip=internal flag for exactly one cycle, then IDLE. The internal clip flag clears on accept.
- Latency and throughput:
  - Accept at edge E0; the DONE cycle begins at edge E(6*NUM_STAGES).
  - One sample per 6*NUM_STAGES+2 cycles.
- Overrun: in_valid while in_ready=0 sets overrun (sticky until reset). That sample is dropped and not queued.
- Config writes:
  - cfg_we writes shadow[cfg_addr] in any state. cfg_addr >= 5*NUM_STAGES is ignored.
  - cfg_commit sets commit_pending.
  - Swap (active<=shadow, commit_pending<=0) happens on an edge where state==IDLE and commit_pending is already 1. This includes the accepting edge, so the accepted sample uses the new coefficients.
  - Writes made on or before the commit cycle are always included in the swap. A write on the swap edge itself is not included.
  - The active bank never changes during MAC, WB or DONE.
  - cfg_commit while commit_pending=1 has no additional effect.

Decomposition:
- Package filter_pkg holds:
  - sample_t, coef_t, acc_t typedefs.
  - tap_e enum (B0, B1, B2, NA1, NA2) and state_e enum (IDLE, MAC, WB, DONE).
  - COEF_ONE=16384 and TAPS_PER_STAGE=5.
  - Saturate/round function: ACC_W to DATA_W with clip flag.
- One sub-module, biquad_mac: combinational sign-extended multiply plus an accumulator register with load/accumulate controls. The sequencer drives the operand muxes and controls.

Test Plan:
- Passthrough after reset, NUM_STAGES=2: in 1000, then -1000 -> out 1000 and -1000. out_valid rises 12 edges after accept; clip=0.
- Gain: shadow stage0 b0=8192, commit, wait -> in 20000 gives out 10000; in 1 gives out 1 (rounding).
- Saturation: b0=32767 in both stages -> in 30000 gives out 32767 with clip=1; in -30000 gives -32768 with clip=1; next in 0 gives clip=0.
- Recursion: stage0 b0=16384, na1=8192; stage1 passthrough -> impulse 16384 then zeros gives 16384, 8192, 4096, 2048, 1024.
- Commit timing: write b0=8192 and commit during MAC of sample A -> A uses passthrough, sample B is halved. commit_pending stays 1 until B's accepting edge.
- Overrun and reset: in_valid pulsed during MAC -> in_ready=0, sample dropped, overrun=1 sticky. Assert reset_n=0 mid-WB -> all outputs at reset values immediately; next sample passes through correctly.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types, constants and the round/saturate helper for the biquad sequencer.
package filter_pkg;

  localparam int DATA_W         = 16;
  localparam int COEF_W         = 16;
  localparam int COEF_FRAC      = 14;
  localparam int ACC_W          = 40;
  localparam int TAPS_PER_STAGE = 5;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {B0, B1, B2, NA1, NA2} tap_e;
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_e;

  localparam coef_t COEF_ONE    = coef_t'(16384);
  // Half an output LSB, so the arithmetic shift rounds half-up.
  localparam acc_t  ROUND_CONST = acc_t'(1) << (COEF_FRAC - 1);
  localparam acc_t  SAMPLE_MAX  = acc_t'((2 ** (DATA_W - 1)) - 1);
  localparam acc_t  SAMPLE_MIN  = -acc_t'(2 ** (DATA_W - 1));

  typedef struct packed {
    sample_t value;
    logic    clip;
  } sat_t;

  // Drop the coefficient fraction and clamp to the sample range.
  function automatic sat_t sat_round(input acc_t acc);
    acc_t shifted;
    sat_t res;
    shifted = acc >>> COEF_FRAC;
    if (shifted > SAMPLE_MAX) begin
      res.value = sample_t'(SAMPLE_MAX);
      res.clip  = 1'b1;
    end else if (shifted < SAMPLE_MIN) begin
      res.value = sample_t'(SAMPLE_MIN);
      res.clip  = 1'b1;
    end else begin
      res.value = shifted[DATA_W-1:0];
      res.clip  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate: signed sample x coefficient product into a wide accumulator.
module biquad_mac
  import filter_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  sample_t a_i,
  input  coef_t   b_i,
  input  logic    load_i,
  input  acc_t    load_val_i,
  input  logic    acc_en_i,
  output acc_t    acc_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  acc_t                     acc_q;

  assign prod  = PROD_W'(a_i) * PROD_W'(b_i);
  assign acc_o = acc_q;

  // Load wins over accumulate so a new stage always starts from the rounding constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= load_val_i;
    end else if (acc_en_i) begin
      acc_q <= acc_q + acc_t'(prod);
    end
  end

endmodule

// File: rtl/biquad_sequencer.sv
// Runs NUM_STAGES cascaded direct-form-I biquads on one shared MAC, one sample at a time.
//
// state | meaning
// IDLE  | ready for a sample; pending coefficient swap is applied here
// MAC   | one tap per cycle, B0..NA2, for the current stage
// WB    | round/saturate, update stage history, advance stage or finish
// DONE  | out_valid/clip presented for one cycle
module biquad_sequencer
  import filter_pkg::*;
#(
  parameter  int NUM_STAGES = 2,
  localparam int NUM_COEF   = TAPS_PER_STAGE * NUM_STAGES,
  localparam int ADDR_W     = $clog2(NUM_COEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  sample_t           in_sample,
  input  logic              in_valid,
  output logic              in_ready,
  output sample_t           out_sample,
  output logic              out_valid,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  coef_t             cfg_data,
  input  logic              cfg_commit,
  output logic              commit_pending,
  output logic              overrun,
  output logic              clip
);

  localparam int                STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LIMIT = ADDR_W'(NUM_COEF);

  state_e             state_q;
  tap_e               tap_q;
  logic [STAGE_W-1:0] stage_q;
  sample_t            cur_x_q;
  sample_t            x1_q [NUM_STAGES];
  sample_t            x2_q [NUM_STAGES];
  sample_t            y1_q [NUM_STAGES];
  sample_t            y2_q [NUM_STAGES];
  sample_t            out_sample_q;
  logic               out_valid_q;
  logic               clip_q;
  logic               clip_flag_q;
  logic               overrun_q;

  coef_t              shadow_q [NUM_COEF];
  coef_t              active_q [NUM_COEF];
  logic               commit_pending_q;

  logic [ADDR_W-1:0]  coef_idx;
  sample_t            mac_a;
  coef_t              mac_b;
  logic               mac_load;
  logic               mac_acc_en;
  acc_t               mac_acc;
  sat_t               sat_res;

  assign in_ready       = (state_q == IDLE);
  assign out_sample     = out_sample_q;
  assign out_valid      = out_valid_q;
  assign clip           = clip_q;
  assign overrun        = overrun_q;
  assign commit_pending = commit_pending_q;

  assign coef_idx   = ADDR_W'(stage_q) * ADDR_W'(TAPS_PER_STAGE) + ADDR_W'(tap_q);
  assign mac_b      = active_q[coef_idx];
  assign mac_load   = (state_q == IDLE && in_valid) || (state_q == WB && stage_q != LAST_STAGE);
  assign mac_acc_en = (state_q == MAC);
  assign sat_res    = sat_round(mac_acc);

  // Sample operand select: the tap index picks the stage input or one of its history terms.
  always_comb begin
    mac_a = cur_x_q;
    case (tap_q)
      B0:      mac_a = cur_x_q;
      B1:      mac_a = x1_q[stage_q];
      B2:      mac_a = x2_q[stage_q];
      NA1:     mac_a = y1_q[stage_q];
      NA2:     mac_a = y2_q[stage_q];
      default: mac_a = cur_x_q;
    endcase
  end

  biquad_mac u_mac (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_i        (mac_a),
    .b_i        (mac_b),
    .load_i     (mac_load),
    .load_val_i (ROUND_CONST),
    .acc_en_i   (mac_acc_en),
    .acc_o      (mac_acc)
  );

  // Sequencer FSM with history, output and sticky status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tap_q        <= B0;
      stage_q      <= '0;
      cur_x_q      <= '0;
      x1_q         <= '{default: '0};
      x2_q         <= '{default: '0};
      y1_q         <= '{default: '0};
      y2_q         <= '{default: '0};
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      clip_q       <= 1'b0;
      clip_flag_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      // A sample offered while busy is dropped; only the sticky flag records it.
      if (in_valid && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cur_x_q     <= in_sample;
            stage_q     <= '0;
            tap_q       <= B0;
            clip_flag_q <= 1'b0;
            state_q     <= MAC;
          end
        end
        MAC: begin
          if (tap_q == NA2) begin
            tap_q   <= B0;
            state_q <= WB;
          end else begin
            tap_q <= tap_e'(tap_q + 3'd1);
          end
        end
        WB: begin
          x2_q[stage_q] <= x1_q[stage_q];
          x1_q[stage_q] <= cur_x_q;
          y2_q[stage_q] <= y1_q[stage_q];
          y1_q[stage_q] <= sat_res.value;
          cur_x_q       <= sat_res.value;
          clip_flag_q   <= clip_flag_q | sat_res.clip;
          if (stage_q == LAST_STAGE) begin
            out_sample_q <= sat_res.value;
            out_valid_q  <= 1'b1;
            clip_q       <= clip_flag_q | sat_res.clip;
            state_q      <= DONE;
          end else begin
            stage_q <= stage_q + 1'b1;
            tap_q   <= B0;
            state_q <= MAC;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Coefficient banks: shadow takes writes any time; active only changes on an IDLE edge
  // with a swap already pending, so a running sample never sees a partial update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[ADDR_W'(i)] <= (i % TAPS_PER_STAGE == 0) ? COEF_ONE : '0;
        active_q[ADDR_W'(i)] <= (i % TAPS_PER_STAGE == 0) ? COEF_ONE : '0;
      end
      commit_pending_q <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr < ADDR_LIMIT) begin
        shadow_q[cfg_addr] <= cfg_data;
      end
      if (state_q == IDLE && commit_pending_q) begin
        active_q         <= shadow_q;
        commit_pending_q <= 1'b0;
      end else if (cfg_commit) begin
        commit_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_biquad_sequencer.sv
module tb_biquad_sequencer;

  localparam int OP_WR  = 0;
  localparam int OP_CM  = 1;
  localparam int OP_SMP = 2;

  typedef struct {
    int op;
    int addr;
    int data;
    int exp;
    int clip;
  } vec_t;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] in_sample;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic signed [15:0] cfg_data;
  logic               cfg_commit;
  logic               commit_pending;
  logic               overrun;
  logic               clip;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int acc_cyc;
  vec_t tbl[$];

  biquad_sequencer #(.NUM_STAGES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_sample      (in_sample),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_sample     (out_sample),
    .out_valid      (out_valid),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .commit_pending (commit_pending),
    .overrun        (overrun),
    .clip           (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int din, input int idx);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_timeout", idx, 0, 1);
    in_valid  = 1'b1;
    in_sample = 16'(din);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic finish(input int exp, input int exp_clip, input int idx);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      chk("out_timeout", idx, 0, 1);
    end else begin
      chk("latency", idx, cyc - acc_cyc, 12);
      chk("out_sample", idx, int'(out_sample), exp);
      chk("clip", idx, int'(clip), exp_clip);
      tick();
      chk("valid_pulse", idx, int'(out_valid), 0);
    end
  endtask

  task automatic do_sample(input int din, input int exp, input int exp_clip, input int idx);
    start(din, idx);
    finish(exp, exp_clip, idx);
  endtask

  task automatic check_reset_outputs(input int idx);
    chk("rst_in_ready", idx, int'(in_ready), 1);
    chk("rst_out_valid", idx, int'(out_valid), 0);
    chk("rst_out_sample", idx, int'(out_sample), 0);
    chk("rst_overrun", idx, int'(overrun), 0);
    chk("rst_clip", idx, int'(clip), 0);
    chk("rst_pending", idx, int'(commit_pending), 0);
  endtask

  initial begin
    int pulses;

    // passthrough
    tbl.push_back('{OP_SMP, 0, 1000, 1000, 0});
    tbl.push_back('{OP_SMP, 0, -1000, -1000, 0});
    // stage0 gain 0.5
    tbl.push_back('{OP_WR, 0, 8192, 0, 0});
    tbl.push_back('{OP_CM, 0, 0, 0, 0});
    tbl.push_back('{OP_SMP, 0, 20000, 10000, 0});
    tbl.push_back('{OP_SMP, 0, 1, 1, 0});
    tbl.push_back('{OP_SMP, 0, -3, -1, 0});
    // near-2x gain in both stages
    tbl.push_back('{OP_WR, 0, 32767, 0, 0});
    tbl.push_back('{OP_WR, 5, 32767, 0, 0});
    tbl.push_back('{OP_CM, 0, 0, 0, 0});
    tbl.push_back('{OP_SMP, 0, 30000, 32767, 1});
    tbl.push_back('{OP_SMP, 0, -30000, -32768, 1});
    tbl.push_back('{OP_SMP, 0, 0, 0, 0});
    tbl.push_back('{OP_SMP, 0, 1, 4, 0});
    tbl.push_back('{OP_SMP, 0, 0, 0, 0});
    // one-pole recursion in stage0, stage1 passthrough
    tbl.push_back('{OP_WR, 0, 16384, 0, 0});
    tbl.push_back('{OP_WR, 3, 8192, 0, 0});
    tbl.push_back('{OP_WR, 5, 16384, 0, 0});
    tbl.push_back('{OP_CM, 0, 0, 0, 0});
    tbl.push_back('{OP_SMP, 0, 16384, 16384, 0});
    tbl.push_back('{OP_SMP, 0, 0, 8192, 0});
    tbl.push_back('{OP_SMP, 0, 0, 4096, 0});
    tbl.push_back('{OP_SMP, 0, 0, 2048, 0});
    tbl.push_back('{OP_SMP, 0, 0, 1024, 0});
    // back to passthrough
    tbl.push_back('{OP_WR, 3, 0, 0, 0});
    tbl.push_back('{OP_CM, 0, 0, 0, 0});
    tbl.push_back('{OP_SMP, 0, 500, 500, 0});

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_sample  = '0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    #2;
    check_reset_outputs(0);
    #20;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_WR: begin
          cfg_we   = 1'b1;
          cfg_addr = 4'(tbl[i].addr);
          cfg_data = 16'(tbl[i].data);
          tick();
          cfg_we = 1'b0;
        end
        OP_CM: begin
          cfg_commit = 1'b1;
          tick();
          cfg_commit = 1'b0;
          chk("pending_set", i, int'(commit_pending), 1);
          tick();
          chk("pending_clear", i, int'(commit_pending), 0);
        end
        default: do_sample(tbl[i].data, tbl[i].exp, tbl[i].clip, i);
      endcase
    end

    // Commit while busy: sample A keeps old bank, sample B picks up the new one.
    start(2000, 100);
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 16'sd8192;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("pending_busy", 100, int'(commit_pending), 1);
    finish(2000, 0, 100);
    chk("pending_idle", 101, int'(commit_pending), 1);
    chk("ready_idle", 101, int'(in_ready), 1);
    start(2000, 101);
    chk("pending_after_accept", 101, int'(commit_pending), 0);
    finish(1000, 0, 101);

    // Overrun: offer a sample mid-MAC; it must be dropped and flagged.
    chk("overrun_before", 200, int'(overrun), 0);
    start(100, 200);
    chk("ready_busy", 200, int'(in_ready), 0);
    in_valid  = 1'b1;
    in_sample = 16'sd9999;
    tick();
    in_valid = 1'b0;
    chk("overrun_set", 200, int'(overrun), 1);
    finish(50, 0, 200);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("dropped_not_queued", 200, pulses, 0);
    chk("overrun_sticky", 200, int'(overrun), 1);

    // Reset in the first WB cycle aborts the sample and restores passthrough.
    start(3000, 300);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs(300);
    #2;
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("aborted_no_output", 300, pulses, 0);
    do_sample(1234, 1234, 0, 301);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
